// File: rtl/wide_add_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// wide_add_sequencer_pkg
// Shared constants for the word-serial wide adder:
//   WORD_W            - width of one datapath word (the shared adder width)
//   ST_IDLE/RUN/DONE  - controller state encoding
// ---------------------------------------------------------------------------
package wide_add_sequencer_pkg;

  localparam int WORD_W = 32;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/wide_add_sequencer_rca.sv
// ---------------------------------------------------------------------------
// wide_add_sequencer_rca
// Purely combinational WORD_W-bit ripple-carry adder shared by every word of
// a wide operation.
// Ports:
//   c_in  - carry into bit 0
//   in1   - first addend word
//   in2   - second addend word
//   sum   - in1 + in2 + c_in (low WORD_W bits)
//   c_out - carry out of the top bit
// ---------------------------------------------------------------------------
module wide_add_sequencer_rca
  import wide_add_sequencer_pkg::*;
(
  output logic              c_out,
  output logic [WORD_W-1:0] sum,
  input  logic              c_in,
  input  logic [WORD_W-1:0] in1,
  input  logic [WORD_W-1:0] in2
);

  // carry[i] is the carry into bit i
  logic [WORD_W:0] carry;

  assign carry[0] = c_in;

  for (genvar gi = 0; gi < WORD_W; gi++) begin : g_fa
    assign sum[gi]     = in1[gi] ^ in2[gi] ^ carry[gi];
    assign carry[gi+1] = (in1[gi] & in2[gi]) | (carry[gi] & (in1[gi] ^ in2[gi]));
  end

  assign c_out = carry[WORD_W];

endmodule

// File: rtl/wide_add_sequencer.sv
// ---------------------------------------------------------------------------
// wide_add_sequencer
// Performs a NUM_WORDS x 32-bit add or subtract by pushing one word per cycle
// (least-significant first) through a single 32-bit ripple-carry adder, with
// the inter-word carry held in a register.
// Ports:
//   clk, rst_n   - clock, synchronous active-low reset
//   start        - request pulse, only honoured while idle
//   sub          - 0: op_a + op_b + c_in, 1: op_a - op_b
//   c_in         - carry into word 0 (add only)
//   op_a, op_b   - operands, captured when start is accepted
//   busy         - operation in progress (RUN or DONE)
//   done         - one-cycle pulse, result/c_out/ovf valid
//   result       - W-bit sum/difference, held until the next operation
//   c_out        - carry out of the top word (sub: 1 = no borrow)
//   ovf          - signed overflow of the W-bit operation
// ---------------------------------------------------------------------------
module wide_add_sequencer
  import wide_add_sequencer_pkg::*;
#(
  parameter  int NUM_WORDS = 4,
  parameter  int IDX_W     = $clog2(NUM_WORDS),
  localparam int W         = WORD_W * NUM_WORDS
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         sub,
  input  logic         c_in,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         c_out,
  output logic         ovf
);

  logic [1:0]       state_q,  state_d;
  logic [IDX_W-1:0] idx_q,    idx_d;
  logic             carry_q,  carry_d;
  logic [W-1:0]     a_q,      a_d;
  logic [W-1:0]     b_q,      b_d;      // already inverted for subtract
  logic [W-1:0]     result_q, result_d;
  logic             c_out_q,  c_out_d;
  logic             ovf_q,    ovf_d;

  // Word views of the captured operands so the adder is fed by idx only
  logic [WORD_W-1:0] a_words [NUM_WORDS];
  logic [WORD_W-1:0] b_words [NUM_WORDS];

  for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_words
    assign a_words[gi] = a_q[gi*WORD_W +: WORD_W];
    assign b_words[gi] = b_q[gi*WORD_W +: WORD_W];
  end

  logic [WORD_W-1:0] a_word, b_word, sum_word;
  logic              add_c_out;
  logic              last_word;

  assign a_word    = a_words[idx_q];
  assign b_word    = b_words[idx_q];
  assign last_word = (idx_q == IDX_W'(NUM_WORDS - 1));

  wide_add_sequencer_rca u_rca (
    .c_out (add_c_out),
    .sum   (sum_word),
    .c_in  (carry_q),
    .in1   (a_word),
    .in2   (b_word)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    c_out_d  = c_out_q;
    ovf_d    = ovf_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d     = op_a;
          // Subtract is A + ~B + 1, so the inversion and forced carry happen here
          b_d     = sub ? ~op_b : op_b;
          carry_d = sub ? 1'b1 : c_in;
          idx_d   = '0;
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        carry_d = add_c_out;
        for (int i = 0; i < NUM_WORDS; i++) begin
          if (idx_q == IDX_W'(i)) begin
            result_d[i*WORD_W +: WORD_W] = sum_word;
          end
        end
        if (last_word) begin
          c_out_d = add_c_out;
          // Operands share a sign but the sum's sign differs
          ovf_d   = (a_word[WORD_W-1] == b_word[WORD_W-1]) &&
                    (sum_word[WORD_W-1] != a_word[WORD_W-1]);
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      c_out_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      c_out_q  <= c_out_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy   = (state_q != ST_IDLE);
  assign done   = (state_q == ST_DONE);
  assign result = result_q;
  assign c_out  = c_out_q;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_wide_add_sequencer.sv
// ---------------------------------------------------------------------------
// tb_wide_add_sequencer
// Drives a 2-word and a 4-word instance and compares every completed
// operation with whole-width arithmetic computed in the bench.
// ---------------------------------------------------------------------------
module tb_wide_add_sequencer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start2, start4;
  logic         sub, c_in;
  logic [127:0] op_a, op_b;

  logic         busy2, done2, cout2, ovf2;
  logic [63:0]  res2;
  logic         busy4, done4, cout4, ovf4;
  logic [127:0] res4;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  wide_add_sequencer #(.NUM_WORDS(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .sub(sub), .c_in(c_in),
    .op_a(op_a[63:0]), .op_b(op_b[63:0]),
    .busy(busy2), .done(done2), .result(res2), .c_out(cout2), .ovf(ovf2)
  );

  wide_add_sequencer #(.NUM_WORDS(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .sub(sub), .c_in(c_in),
    .op_a(op_a), .op_b(op_b),
    .busy(busy4), .done(done4), .result(res4), .c_out(cout4), .ovf(ovf4)
  );

  task automatic check_val(input string tag, input logic [127:0] got,
                           input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: plain W-bit arithmetic, subtraction as two's complement
  task automatic model(input int n, input logic [127:0] a, input logic [127:0] b,
                       input logic s, input logic ci,
                       output logic [127:0] r, output logic co, output logic ov);
    int           w;
    logic [128:0] mask, am, bm, full;
    w    = 32 * n;
    mask = (129'd1 << w) - 129'd1;
    am   = {1'b0, a} & mask;
    bm   = (s ? ~{1'b0, b} : {1'b0, b}) & mask;
    full = am + bm + (s ? 129'd1 : {128'd0, ci});
    r    = full[127:0] & mask[127:0];
    co   = full[w];
    ov   = (am[w-1] == bm[w-1]) && (r[w-1] != am[w-1]);
  endtask

  function automatic logic dn(input int n);
    return (n == 2) ? done2 : done4;
  endfunction
  function automatic logic bz(input int n);
    return (n == 2) ? busy2 : busy4;
  endfunction
  function automatic logic [127:0] rs(input int n);
    return (n == 2) ? {64'd0, res2} : res4;
  endfunction
  function automatic logic co_f(input int n);
    return (n == 2) ? cout2 : cout4;
  endfunction
  function automatic logic ov_f(input int n);
    return (n == 2) ? ovf2 : ovf4;
  endfunction

  // Called at a negedge while the instance is idle; returns at the negedge
  // after E_N+1, so a following call starts at E_N+2 (back-to-back).
  task automatic do_op(input int n, input logic [127:0] a, input logic [127:0] b,
                       input logic s, input logic ci, input string tag);
    logic [127:0] er;
    logic         eco, eov;
    int           k;
    model(n, a, b, s, ci, er, eco, eov);
    op_a = a; op_b = b; sub = s; c_in = ci;
    if (n == 2) start2 = 1'b1; else start4 = 1'b1;
    @(posedge clk);                     // E0
    @(negedge clk);
    start2 = 1'b0; start4 = 1'b0;
    // Scramble live inputs: only the captured copies may be used
    op_a = {$urandom(), $urandom(), $urandom(), $urandom()};
    op_b = {$urandom(), $urandom(), $urandom(), $urandom()};
    sub  = 1'($urandom()); c_in = 1'($urandom());
    check_val({tag, " busy_run"}, {127'd0, bz(n)}, 128'd1);
    k = 0;
    while (k < n + 4 && !dn(n)) begin
      @(negedge clk);
      k++;
    end
    check_val({tag, " latency"}, k, n);
    check_val({tag, " result"}, rs(n), er);
    check_val({tag, " c_out"}, {127'd0, co_f(n)}, {127'd0, eco});
    check_val({tag, " ovf"}, {127'd0, ov_f(n)}, {127'd0, eov});
    check_val({tag, " busy_done"}, {127'd0, bz(n)}, 128'd1);
    @(negedge clk);                     // after E_N+1
    check_val({tag, " done_pulse"}, {127'd0, dn(n)}, 128'd0);
    check_val({tag, " busy_idle"}, {127'd0, bz(n)}, 128'd0);
    check_val({tag, " result_hold"}, rs(n), er);
    $display("op %s n=%0d sub=%0b a=%h b=%h res=%h c_out=%0b ovf=%0b",
             tag, n, s, a, b, rs(n), co_f(n), ov_f(n));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    logic [127:0] er, a, b, word;
    logic         eco, eov, s;
    int           k, n, extra;

    rst_n = 1'b0; start2 = 1'b0; start4 = 1'b0; sub = 1'b0; c_in = 1'b0;
    op_a = '0; op_b = '0;
    repeat (3) @(negedge clk);
    check_val("rst busy2", {127'd0, busy2}, 128'd0);
    check_val("rst done2", {127'd0, done2}, 128'd0);
    check_val("rst res2", {64'd0, res2}, 128'd0);
    check_val("rst cout2", {127'd0, cout2}, 128'd0);
    check_val("rst ovf2", {127'd0, ovf2}, 128'd0);
    check_val("rst busy4", {127'd0, busy4}, 128'd0);
    check_val("rst res4", res4, 128'd0);
    rst_n = 1'b1;

    do_op(2, 128'h0000_0000_FFFF_FFFF, 128'd1, 1'b0, 1'b0, "add_carry");
    do_op(2, 128'hFFFF_FFFF_FFFF_FFFF, 128'd0, 1'b0, 1'b1, "full_ripple");
    do_op(2, 128'd5, 128'd7, 1'b1, 1'b0, "sub_borrow");
    do_op(2, 128'd7, 128'd5, 1'b1, 1'b1, "sub_noborrow");
    do_op(2, 128'h7FFF_FFFF_FFFF_FFFF, 128'd1, 1'b0, 1'b0, "signed_ovf");

    // start held high through a whole operation, operands changed after E0
    a = 128'h1234_5678_9ABC_DEF0; b = 128'h0FED_CBA9_8765_4321;
    model(2, a, b, 1'b0, 1'b1, er, eco, eov);
    op_a = a; op_b = b; sub = 1'b0; c_in = 1'b1; start2 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    op_a = ~a; op_b = ~b; sub = 1'b1; c_in = 1'b0;
    k = 0;
    while (k < 6 && !done2) begin
      @(negedge clk);
      k++;
    end
    start2 = 1'b0;
    check_val("hold latency", k, 2);
    check_val("hold result", {64'd0, res2}, er);
    check_val("hold c_out", {127'd0, cout2}, {127'd0, eco});
    extra = 0;
    repeat (4) begin
      @(negedge clk);
      if (done2 || busy2) extra++;
    end
    check_val("hold single_op", extra, 0);
    $display("op hold n=2 res=%h extra_cycles=%0d", res2, extra);

    // reset at E1 aborts the operation
    op_a = 128'hAAAA_AAAA_5555_5555; op_b = 128'd3; sub = 1'b0; c_in = 1'b0;
    start2 = 1'b1;
    @(posedge clk);                     // E0
    @(negedge clk);
    start2 = 1'b0; rst_n = 1'b0;
    @(negedge clk);                     // after E1
    check_val("abort busy", {127'd0, busy2}, 128'd0);
    check_val("abort done", {127'd0, done2}, 128'd0);
    check_val("abort result", {64'd0, res2}, 128'd0);
    check_val("abort c_out", {127'd0, cout2}, 128'd0);
    rst_n = 1'b1;
    extra = 0;
    repeat (5) begin
      @(negedge clk);
      if (done2) extra++;
    end
    check_val("abort no_done", extra, 0);
    $display("op abort n=2 res=%h", res2);

    do_op(4, 128'd12365438, 128'd98745672, 1'b0, 1'b0, "w4_small");
    do_op(4, {128{1'b1}}, 128'd0, 1'b0, 1'b1, "w4_ripple");
    do_op(4, 128'd0, 128'd1, 1'b1, 1'b0, "w4_zero_minus_one");

    for (int i = 0; i < 40; i++) begin
      n = ($urandom_range(0, 1) == 0) ? 2 : 4;
      for (int j = 0; j < 4; j++) begin
        word = 128'($urandom());
        if ($urandom_range(0, 3) == 0) word = 128'hFFFF_FFFF;
        a[j*32 +: 32] = word[31:0];
      end
      case ($urandom_range(0, 2))
        0: b = {$urandom(), $urandom(), $urandom(), $urandom()};
        1: b = ~a;
        default: b = 128'($urandom_range(0, 3));
      endcase
      s = 1'($urandom());
      do_op(n, a, b, s, 1'($urandom()), $sformatf("rand%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/wide_add_sequencer.md
Name: wide_add_sequencer

Overview:
Multi-cycle controller that performs NUM_WORDS×32-bit add/subtract by time-sharing one 32-bit ripple-carry adder, one word per cycle, least-significant word first. The inter-word carry is held in a register between cycles. Sits between a requesting unit, which uses a start/busy/done handshake, and the 32-bit adder datapath. Lets wide arithmetic (64/128-bit) reuse the existing single-word adder instead of a wider combinational chain.

Parameters:
NUM_WORDS, 4, number of 32-bit words per operand (>=2); total width W = 32*NUM_WORDS
IDX_W, $clog2(NUM_WORDS), width of the word index counter

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous reset, active-low; sampled on rising clk edge
start  input  1  request pulse; sampled only in IDLE
sub  input  1  0 = A+B+c_in, 1 = A-B (B inverted, carry-in forced 1, c_in ignored)
c_in  input  1  carry into word 0 (add only)
op_a  input  W  operand A, captured on start acceptance
op_b  input  W  operand B, captured on start acceptance
busy  output  1  high in RUN and DONE
done  output  1  one-cycle pulse, result valid
result  output  W  sum/difference; held stable from done until next accepted start
c_out  output  1  carry out of the top word (sub: 1 = no borrow)
ovf  output  1  signed overflow of the W-bit operation

Behaviour:
- Clock and reset: single clock clk; reset rst_n is synchronous and active-low.
- Reset (rst_n=0 at an edge): state=IDLE, idx=0, carry reg=0, busy=0, done=0, result=0, c_out=0, ovf=0. Operand registers cleared.
- States:
  - IDLE: busy=0. If start=1 at edge E0: capture op_a; capture op_b (or ~op_b if sub); carry<=sub?1:c_in; idx<=0; go to RUN. result is not cleared until the first word is written.
  - RUN: each edge, the adder computes a_reg[idx]+b_reg[idx]+carry. result[32*idx+:32]<=sum; carry<=adder c_out; idx<=idx+1.
    - At the edge with idx=NUM_WORDS-1: c_out<=adder c_out; ovf<=(a_msb==b_msb_eff)&&(sum_msb!=a_msb); go to DONE.
  - DONE: done=1 for exactly this one cycle; busy=1. Next edge: go to IDLE, done<=0.
- Latency: words are written at edges E1..E_N (N=NUM_WORDS). done is high between E_N and E_N+1. A new start is accepted no earlier than E_N+2 (back-to-back throughput N+2 cycles).
- start while busy=1 is ignored: no queuing, no effect on operands.
- Operand inputs may change freely after E0; only the captured copies are used.
- idx never wraps within an operation. The counter is reset to 0 on every acceptance.
- Carry chain: the registered carry is the only inter-word link. Full propagation across all words (e.g. 0xFF..F + 1) must be correct.
- Reset asserted in RUN or DONE: abort immediately. No done pulse. All outputs return to reset values at that edge.
- start and rst_n=0 at the same edge: reset wins.
- The adder is purely combinational. Its inputs are driven only from the capture registers and the carry register, never from live ports.

Decomposition:
- Shared package: state encoding constants (ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2) and WORD_W=32.
- One sub-module: instance of the existing 32-bit ripple-carry adder (ports c_out, sum, c_in, in1, in2), driven by idx-selected word slices.
- Controller FSM, index counter, capture registers and result register all live in wide_add_sequencer.

Test Plan (NUM_WORDS=2 unless stated):
1. Reset then add: a=64'h0000_0000_FFFF_FFFF, b=1, c_in=0, start -> done at E3; result=64'h0000_0001_0000_0000, c_out=0, ovf=0.
2. Full carry ripple: a=64'hFFFF_FFFF_FFFF_FFFF, b=0, c_in=1 -> result=0, c_out=1, ovf=0.
3. Subtract with borrow: sub=1, a=5, b=7 -> result=64'hFFFF_FFFF_FFFF_FFFE, c_out=0; then a=7, b=5 -> result=2, c_out=1.
4. Signed overflow: a=64'h7FFF_FFFF_FFFF_FFFF, b=1 -> result=64'h8000_0000_0000_0000, ovf=1, c_out=0.
5. Protocol checks:
   - start held high through a whole operation plus operand changes at E1 -> exactly one operation, result uses E0 operands.
   - Next start accepted at E_N+2.
   - done high for exactly one cycle.
6. Reset mid-RUN at E1 -> no done; busy=0, result=0 after that edge. NUM_WORDS=4 regression: 12365438+98745672 in word 0 with zeros elsewhere -> result=111111110, done at E5.
